// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer.
// Steps each instruction through its states and drives datapath strobes.
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             rdy;

  assign rdy     = WAIT_MEM ? mem_ready : 1'b1;
  assign state   = rst ? 4'd0 : state_q;
  assign retired = rst ? '0 : retired_q;

  // Next-state, retire strobe and datapath controls decoded from state.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (rdy) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW,
            OP_SW:   state_d = MEMADR;
            OP_R:    state_d = RTEX;
            OP_BEQ:  state_d = BEQEX;
            OP_ADDI: state_d = ADDIEX;
            OP_J:    state_d = JEX;
            default: begin
              state_d = FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (rdy) state_d = MEMWB;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (rdy) begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
        RTEX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = RTWB;
        end
        RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        BEQEX: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
          state_d       = FETCH;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ADDIWB;
        end
        ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        JEX: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        default: begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      endcase
    end
  end

  // State register and wrapping retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control sequencer.
// Checks per-cycle state, strobe bundle and retired count.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal;
  logic [3:0] state;
  logic [3:0] retired;

  int compared = 0;
  int mism     = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(4), .WAIT_MEM(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .state         (state),
    .retired       (retired)
  );

  // pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb op pcsrc ill
  logic [16:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal};

  localparam logic [16:0] C_ZERO = 17'b0;
  localparam logic [16:0] C_FR   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FNR  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_RTEX = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RTWB = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BEQ  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_AIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_JEX  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

  task automatic chk_st(input string tag, input logic [3:0] es,
                        input logic [16:0] ec);
    #1;
    compared++;
    assert (state === es) else begin
      mism++;
      $error("FAIL %s state: got %0d want %0d", tag, state, es);
    end
    compared++;
    assert (ctl === ec) else begin
      mism++;
      $error("FAIL %s ctl: got %b want %b", tag, ctl, ec);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [3:0] er);
    #1;
    compared++;
    assert (retired === er) else begin
      mism++;
      $error("FAIL %s retired: got %0d want %0d", tag, retired, er);
    end
  endtask

  // Check current cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [3:0] es,
                     input logic [16:0] ec);
    chk_st(tag, es, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    cyc("rst0", 4'd0, C_ZERO);
    chk_ret("rst0", 4'd0);
    cyc("rst1", 4'd0, C_ZERO);
    chk_ret("rst1", 4'd0);
    rst = 1'b0;

    // lw, no wait states
    opcode = 6'b100011;
    cyc("lw_f", 4'd0, C_FR);
    chk_ret("lw_f", 4'd0);
    cyc("lw_d", 4'd1, C_DEC);
    cyc("lw_a", 4'd2, C_MADR);
    cyc("lw_r", 4'd3, C_MRD);
    cyc("lw_wb", 4'd4, C_MWB);
    chk_ret("lw_done", 4'd1);

    // sw with two wait cycles in MEMWR
    opcode = 6'b101011;
    cyc("sw_f", 4'd0, C_FR);
    cyc("sw_d", 4'd1, C_DEC);
    cyc("sw_a", 4'd2, C_MADR);
    mem_ready = 1'b0;
    cyc("sw_w0", 4'd5, C_MWR);
    cyc("sw_w1", 4'd5, C_MWR);
    mem_ready = 1'b1;
    cyc("sw_w2", 4'd5, C_MWR);
    chk_ret("sw_done", 4'd2);

    // beq then j
    opcode = 6'b000100;
    cyc("beq_f", 4'd0, C_FR);
    cyc("beq_d", 4'd1, C_DEC);
    cyc("beq_x", 4'd8, C_BEQ);
    chk_ret("beq_done", 4'd3);
    opcode = 6'b000010;
    cyc("j_f", 4'd0, C_FR);
    cyc("j_d", 4'd1, C_DEC);
    cyc("j_x", 4'd11, C_JEX);
    chk_ret("j_done", 4'd4);

    // illegal opcode
    opcode = 6'b111111;
    cyc("ill_f", 4'd0, C_FR);
    cyc("ill_d", 4'd1, C_DILL);
    chk_st("ill_back", 4'd0, C_FR);
    chk_ret("ill_ret", 4'd4);

    // addi
    opcode = 6'b001000;
    cyc("addi_f", 4'd0, C_FR);
    cyc("addi_d", 4'd1, C_DEC);
    cyc("addi_x", 4'd9, C_MADR);
    cyc("addi_wb", 4'd10, C_AIWB);
    chk_ret("addi_done", 4'd5);

    // lw with one wait cycle in MEMRD
    opcode = 6'b100011;
    cyc("lw2_f", 4'd0, C_FR);
    cyc("lw2_d", 4'd1, C_DEC);
    cyc("lw2_a", 4'd2, C_MADR);
    mem_ready = 1'b0;
    cyc("lw2_r0", 4'd3, C_MRD);
    mem_ready = 1'b1;
    cyc("lw2_r1", 4'd3, C_MRD);
    cyc("lw2_wb", 4'd4, C_MWB);
    chk_ret("lw2_done", 4'd6);

    // reset while in MEMRD
    cyc("rlw_f", 4'd0, C_FR);
    cyc("rlw_d", 4'd1, C_DEC);
    cyc("rlw_a", 4'd2, C_MADR);
    chk_st("rlw_r", 4'd3, C_MRD);
    rst = 1'b1;
    chk_st("rlw_rst", 4'd0, C_ZERO);
    chk_ret("rlw_rst", 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_st("rlw_after", 4'd0, C_FR);
    chk_ret("rlw_after", 4'd0);

    // FETCH stall
    mem_ready = 1'b0;
    cyc("fstall0", 4'd0, C_FNR);
    cyc("fstall1", 4'd0, C_FNR);
    mem_ready = 1'b1;

    // 16 R-type instructions wrap the 4-bit counter
    opcode = 6'b000000;
    for (int i = 0; i < 16; i++) begin
      cyc("r_f", 4'd0, C_FR);
      cyc("r_d", 4'd1, C_DEC);
      cyc("r_x", 4'd6, C_RTEX);
      cyc("r_wb", 4'd7, C_RTWB);
      chk_ret("r_cnt", 4'((i + 1) % 16));
    end
    chk_st("end", 4'd0, C_FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
